// File: rtl/game_flow_controller.sv
// Game-flow sequencer: owns lives, score and the level state machine, and gates
// the ball controller through unitActive. All outputs are registered.
module game_flow_controller #(
  parameter int LIVES_INIT    = 3,
  parameter int FREEZE_FRAMES = 60,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               col_player_ball,
  input  logic               col_rope_ball,
  input  logic               hugeBallVisible,
  input  logic               bigBall1Visible,
  input  logic               bigBall2Visible,
  output logic               unitActive,
  output logic               playerFreeze,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               levelWin,
  output logic               gameOver
);

  typedef enum logic [2:0] {IDLE, PLAY, HIT, CLEAR, OVER} state_t;

  state_t     state;
  logic       startPrev;
  logic       playerPrev;
  logic       ropePrev;
  logic       seenBall;
  logic [7:0] freezeCnt;

  logic startRise;
  logic playerRise;
  logic ropeRise;
  logic anyVisible;

  assign startRise  = startKey & ~startPrev;
  assign playerRise = col_player_ball & ~playerPrev;
  assign ropeRise   = col_rope_ball & ~ropePrev;
  assign anyVisible = hugeBallVisible | bigBall1Visible | bigBall2Visible;

  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      startPrev    <= 1'b0;
      playerPrev   <= 1'b0;
      ropePrev     <= 1'b0;
      seenBall     <= 1'b0;
      freezeCnt    <= 8'd0;
      unitActive   <= 1'b0;
      playerFreeze <= 1'b0;
      lives        <= 3'd0;
      score        <= '0;
      levelWin     <= 1'b0;
      gameOver     <= 1'b0;
    end else begin
      startPrev  <= startKey;
      playerPrev <= col_player_ball;
      ropePrev   <= col_rope_ball;
      case (state)
        IDLE: begin
          if (startRise) begin
            state      <= PLAY;
            unitActive <= 1'b1;
            lives      <= 3'(LIVES_INIT);
            score      <= '0;
            seenBall   <= 1'b0;
          end
        end
        PLAY: begin
          if (anyVisible) seenBall <= 1'b1;
          if (ropeRise) score <= satInc(score);
          // A player hit wins over a simultaneous level clear.
          if (playerRise) begin
            unitActive <= 1'b0;
            if (lives == 3'd1) begin
              state    <= OVER;
              lives    <= 3'd0;
              gameOver <= 1'b1;
            end else begin
              state        <= HIT;
              lives        <= lives - 3'd1;
              freezeCnt    <= 8'(FREEZE_FRAMES);
              playerFreeze <= 1'b1;
            end
          end else if (seenBall && !anyVisible) begin
            state      <= CLEAR;
            unitActive <= 1'b0;
            levelWin   <= 1'b1;
          end
        end
        HIT: begin
          if (startOfFrame) begin
            if (freezeCnt == 8'd1) begin
              state        <= PLAY;
              freezeCnt    <= 8'd0;
              playerFreeze <= 1'b0;
              unitActive   <= 1'b1;
              seenBall     <= 1'b0;
            end else begin
              freezeCnt <= freezeCnt - 8'd1;
            end
          end
        end
        CLEAR: begin
          if (startRise) begin
            state      <= PLAY;
            levelWin   <= 1'b0;
            unitActive <= 1'b1;
            seenBall   <= 1'b0;
          end
        end
        OVER: begin
          if (startRise) begin
            state    <= IDLE;
            gameOver <= 1'b0;
            score    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus random play, checked
// every cycle against a mode-based behavioural model.
module tb_game_flow_controller;

  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame, startKey, col_player_ball, col_rope_ball;
  logic          hugeBallVisible, bigBall1Visible, bigBall2Visible;
  logic          unitActive, playerFreeze, levelWin, gameOver;
  logic [2:0]    lives;
  logic [SW-1:0] score;

  int compared = 0;
  int mismatched = 0;
  bit running = 1'b0;

  game_flow_controller #(.LIVES_INIT(3), .FREEZE_FRAMES(60), .SCORE_W(SW)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .col_player_ball(col_player_ball), .col_rope_ball(col_rope_ball),
    .hugeBallVisible(hugeBallVisible), .bigBall1Visible(bigBall1Visible),
    .bigBall2Visible(bigBall2Visible), .unitActive(unitActive),
    .playerFreeze(playerFreeze), .lives(lives), .score(score),
    .levelWin(levelWin), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 play, 2 frozen after hit, 3 cleared, 4 game over.
  int mMode, mLives, mScore, mFreeze;
  bit mSeen, pStart, pPlayer, pRope;
  bit sRise, pRise, rRise, vis;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mMode = 0; mLives = 0; mScore = 0; mFreeze = 0; mSeen = 0;
      pStart = 0; pPlayer = 0; pRope = 0;
    end else begin
      sRise = startKey && !pStart;
      pRise = col_player_ball && !pPlayer;
      rRise = col_rope_ball && !pRope;
      vis   = hugeBallVisible || bigBall1Visible || bigBall2Visible;
      pStart = startKey; pPlayer = col_player_ball; pRope = col_rope_ball;
      if (mMode == 0) begin
        if (sRise) begin mMode = 1; mLives = 3; mScore = 0; mSeen = 0; end
      end else if (mMode == 1) begin
        if (rRise && mScore < (1 << SW) - 1) mScore = mScore + 1;
        if (pRise) begin
          if (mLives == 1) begin mLives = 0; mMode = 4; end
          else begin mLives = mLives - 1; mMode = 2; mFreeze = 60; end
        end else if (mSeen && !vis) mMode = 3;
        if (vis) mSeen = 1;
      end else if (mMode == 2) begin
        if (startOfFrame) begin
          mFreeze = mFreeze - 1;
          if (mFreeze == 0) begin mMode = 1; mSeen = 0; end
        end
      end else if (mMode == 3) begin
        if (sRise) begin mMode = 1; mSeen = 0; end
      end else begin
        if (sRise) begin mMode = 0; mScore = 0; end
      end
    end
  end

  function automatic logic [SW+6:0] dutVec();
    return {unitActive, playerFreeze, levelWin, gameOver, lives, score};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (running)
      chk("model", 32'(dutVec()),
          32'({mMode == 1, mMode == 2, mMode == 3, mMode == 4, 3'(mLives), SW'(mScore)}));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sofPulses(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick(); tick();
    end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 0; startKey = 0; col_player_ball = 0; col_rope_ball = 0;
    hugeBallVisible = 0; bigBall1Visible = 0; bigBall2Visible = 0;
    repeat (3) tick();
    running = 1'b1;
    chk("reset_outputs", 32'(dutVec()), 32'd0);
    resetN = 1'b1;
    tick();

    startKey = 1'b1; tick();
    chk("start_play", 32'({unitActive, lives, score}), 32'({1'b1, 3'd3, 8'd0}));
    startKey = 1'b0;

    col_rope_ball = 1'b1; repeat (10) tick(); col_rope_ball = 1'b0; tick();
    col_rope_ball = 1'b1; tick(); col_rope_ball = 1'b0; tick();
    col_rope_ball = 1'b1; tick(); col_rope_ball = 1'b0; tick();
    chk("rope_score", 32'(score), 32'd3);

    col_player_ball = 1'b1; tick(); col_player_ball = 1'b0;
    chk("hit_enter", 32'({lives, unitActive, playerFreeze}), 32'({3'd2, 1'b0, 1'b1}));
    sofPulses(59);
    chk("hit_59", 32'({unitActive, playerFreeze}), 32'({1'b0, 1'b1}));
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    chk("hit_60", 32'({unitActive, playerFreeze}), 32'({1'b1, 1'b0}));

    tick(); tick(); hugeBallVisible = 1'b1; repeat (5) tick();
    hugeBallVisible = 1'b0; tick();
    chk("level_win", 32'({levelWin, unitActive}), 32'({1'b1, 1'b0}));

    startKey = 1'b1; tick(); startKey = 1'b0; repeat (10) tick();
    chk("no_false_win", 32'({levelWin, unitActive, score}), 32'({1'b0, 1'b1, 8'd3}));

    hugeBallVisible = 1'b1; repeat (3) tick();
    hugeBallVisible = 1'b0; col_player_ball = 1'b1; col_rope_ball = 1'b1; tick();
    col_player_ball = 1'b0; col_rope_ball = 1'b0;
    chk("hit_beats_clear", 32'({playerFreeze, levelWin, lives, score}),
        32'({1'b1, 1'b0, 3'd1, 8'd4}));
    #2 resetN = 1'b0;
    #1 chk("async_reset", 32'(dutVec()), 32'd0);
    tick(); resetN = 1'b1; tick();

    startKey = 1'b1; tick(); startKey = 1'b0;
    for (int h = 0; h < 3; h++) begin
      col_player_ball = 1'b1; tick(); col_player_ball = 1'b0; tick();
      if (h < 2) sofPulses(60);
    end
    chk("game_over", 32'({gameOver, lives, unitActive}), 32'({1'b1, 3'd0, 1'b0}));
    startKey = 1'b1; tick(); startKey = 1'b0;
    chk("over_to_idle", 32'(dutVec()), 32'd0);
    tick(); startKey = 1'b1; tick(); startKey = 1'b0;
    chk("restart_lives", 32'({lives, unitActive}), 32'({3'd3, 1'b1}));

    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 15) == 0) startKey = ~startKey;
      if ($urandom_range(0, 39) == 0) col_player_ball = ~col_player_ball;
      if ($urandom_range(0, 7) == 0) col_rope_ball = ~col_rope_ball;
      if ($urandom_range(0, 19) == 0) hugeBallVisible = ~hugeBallVisible;
      if ($urandom_range(0, 19) == 0) bigBall1Visible = ~bigBall1Visible;
      if ($urandom_range(0, 19) == 0) bigBall2Visible = ~bigBall2Visible;
      startOfFrame = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2999) == 0) begin
        #2 resetN = 1'b0;
        tick();
        resetN = 1'b1;
      end else begin
        tick();
      end
    end

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
